// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM: states, opcodes,
// datapath select values and the internal control bundle.
package riscv_ctrl_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned IMM_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    ALUWB  = 4'd7,
    EXECI  = 4'd8,
    JAL    = 4'd9,
    BEQ    = 4'd10,
    LUI    = 4'd11,
    AUIPC  = 4'd12,
    TRAP   = 4'd13
  } state_e;

  localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I     = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI   = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [IMM_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_W-1:0] IMM_U = 3'b100;

  // Per-state control bundle; branch is kept apart from pcUpdate so zero can gate it.
  typedef struct packed {
    logic       memReq;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic       pcUpdate;
    logic       branch;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control-path bundle between the instruction register/datapath and the
// multicycle control FSM.
interface multicycle_control_fsm_if
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) ();

  logic [OP_W-1:0]    op;
  logic               zero;
  logic               mem_ready;
  logic               mem_req;
  logic               adr_src;
  logic               mem_write;
  logic               ir_write;
  logic               pc_write;
  logic               reg_write;
  logic [1:0]         result_src;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [IMM_W-1:0]   imm_src;
  logic               illegal_op;
  logic [CNT_W-1:0]   instret;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, zero, mem_ready,
    output mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src,
           illegal_op, instret, state_o
  );

  modport slave (
    output op, zero, mem_ready,
    input  mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src,
           illegal_op, instret, state_o
  );

endinterface

// File: rtl/riscv_imm_decoder.sv
// Opcode to immediate-format select; purely combinational so the extender
// is steered as soon as the IR is loaded.
module riscv_imm_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [IMM_W-1:0] immSrc
);

  always_comb begin
    immSrc = IMM_I;
    case (op)
      OP_SW:             immSrc = IMM_S;
      OP_BEQ:            immSrc = IMM_B;
      OP_JAL:            immSrc = IMM_J;
      OP_LUI, OP_AUIPC:  immSrc = IMM_U;
      default:           immSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle main control: sequences every datapath select/enable per state,
// handshakes memory via req/ready, traps illegal opcodes and counts retirements.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ENABLE_UTYPE = 1'b1
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_fsm_if.master bus
);

  state_e           state;
  state_e           nextState;
  logic [CNT_W-1:0] instretQ;
  logic             illegalQ;
  logic             retire;
  ctrl_t            ctrl;
  logic [IMM_W-1:0] immSrc;

  riscv_imm_decoder uImmDec (
    .op     (bus.op),
    .immSrc (immSrc)
  );

  // State, retirement counter and sticky trap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      instretQ <= '0;
      illegalQ <= 1'b0;
    end else begin
      state <= nextState;
      if (retire) begin
        instretQ <= instretQ + CNT_W'(1);
      end
      if (nextState == TRAP) begin
        illegalQ <= 1'b1;
      end
    end
  end

  always_comb begin
    nextState = state;
    retire    = 1'b0;
    ctrl      = '0;
    case (state)
      FETCH: begin
        ctrl.memReq    = 1'b1;
        ctrl.aluSrcA   = SRCA_PC;
        ctrl.aluSrcB   = SRCB_FOUR;
        ctrl.resultSrc = RES_ALURESULT;
        if (bus.mem_ready) begin
          ctrl.irWrite  = 1'b1;
          ctrl.pcUpdate = 1'b1;
          nextState     = DECODE;
        end
      end
      DECODE: begin
        ctrl.aluSrcA = SRCA_OLDPC;
        ctrl.aluSrcB = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_R:         nextState = EXECR;
          OP_I:         nextState = EXECI;
          OP_BEQ:       nextState = BEQ;
          OP_JAL:       nextState = JAL;
          OP_LUI:       nextState = ENABLE_UTYPE ? LUI : TRAP;
          OP_AUIPC:     nextState = ENABLE_UTYPE ? AUIPC : TRAP;
          default:      nextState = TRAP;
        endcase
      end
      MEMADR: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_IMM;
        nextState    = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        ctrl.memReq = 1'b1;
        ctrl.adrSrc = 1'b1;
        if (bus.mem_ready) begin
          nextState = MEMWB;
        end
      end
      MEMWB: begin
        ctrl.resultSrc = RES_READDATA;
        ctrl.regWrite  = 1'b1;
        retire         = 1'b1;
        nextState      = FETCH;
      end
      MEMWR: begin
        ctrl.memReq   = 1'b1;
        ctrl.adrSrc   = 1'b1;
        ctrl.memWrite = 1'b1;
        if (bus.mem_ready) begin
          retire    = 1'b1;
          nextState = FETCH;
        end
      end
      EXECR: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_RS2;
        ctrl.aluOp   = ALU_FUNCT;
        nextState    = ALUWB;
      end
      ALUWB: begin
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.regWrite  = 1'b1;
        retire         = 1'b1;
        nextState      = FETCH;
      end
      EXECI: begin
        ctrl.aluSrcA = SRCA_RS1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_FUNCT;
        nextState    = ALUWB;
      end
      // Link value PC+4 goes through the ALU while the target held in ALUOut loads PC.
      JAL: begin
        ctrl.aluSrcA   = SRCA_OLDPC;
        ctrl.aluSrcB   = SRCB_FOUR;
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.pcUpdate  = 1'b1;
        nextState      = ALUWB;
      end
      BEQ: begin
        ctrl.aluSrcA   = SRCA_RS1;
        ctrl.aluSrcB   = SRCB_RS2;
        ctrl.aluOp     = ALU_SUB;
        ctrl.resultSrc = RES_ALUOUT;
        ctrl.branch    = 1'b1;
        retire         = 1'b1;
        nextState      = FETCH;
      end
      LUI: begin
        ctrl.aluSrcA = SRCA_ZERO;
        ctrl.aluSrcB = SRCB_IMM;
        nextState    = ALUWB;
      end
      AUIPC: begin
        ctrl.aluSrcA = SRCA_OLDPC;
        ctrl.aluSrcB = SRCB_IMM;
        nextState    = ALUWB;
      end
      TRAP: begin
        nextState = TRAP;
      end
      default: begin
        nextState = TRAP;
      end
    endcase
  end

  assign bus.mem_req    = ctrl.memReq;
  assign bus.adr_src    = ctrl.adrSrc;
  assign bus.mem_write  = ctrl.memWrite;
  assign bus.ir_write   = ctrl.irWrite;
  assign bus.pc_write   = ctrl.pcUpdate | (ctrl.branch & bus.zero);
  assign bus.reg_write  = ctrl.regWrite;
  assign bus.result_src = ctrl.resultSrc;
  assign bus.alu_src_a  = ctrl.aluSrcA;
  assign bus.alu_src_b  = ctrl.aluSrcB;
  assign bus.alu_op     = ctrl.aluOp;
  assign bus.imm_src    = immSrc;
  assign bus.illegal_op = illegalQ;
  assign bus.instret    = instretQ;
  assign bus.state_o    = state;

endmodule
